// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage sitting directly in front of decode. It owns the program
// counter, reads one instruction word at a time from instruction memory over
// a req/ack handshake, and hands each word to decode over valid/ready.
// Taken jumps/branches arrive as redirects; a response that was already in
// flight when a redirect arrived is thrown away.
//
// Ports:
//   CLK, RSTn        clock, asynchronous active-low reset
//   IMemReq          read request to instruction memory
//   IMemAddr         word address of the request (bits [1:0] always 0)
//   IMemAck          memory accepts the request, IMemRData valid same cycle
//   IMemRData        instruction word from memory
//   Instr, PC        instruction presented to decode and its address
//   PCPlus4          PC + 4
//   InstrValid       Instr/PC hold a real instruction
//   InstrReady       decode consumes Instr this cycle
//   Redirect         taken jump or branch
//   RedirectTarget   new fetch address
//   Misalign         one-cycle pulse: accepted redirect target was misaligned
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RSTn,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemRData,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        InstrValid,
    input  logic        InstrReady,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic        Misalign
);

    // BOOT: idle cycle after reset; REQ: live request; DRAIN: request whose
    // answer is stale and will be discarded; HOLD: instruction waiting on decode.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [31:0] fetch_pc;
    logic [31:0] pending_target;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        instr_valid_q;
    logic        misalign_q;

    logic [31:0] aligned_target;
    logic        redirect_taken;

    assign aligned_target = {RedirectTarget[31:2], 2'b00};
    // Redirects are ignored only in the single boot cycle.
    assign redirect_taken = Redirect && (state != BOOT);

    // State register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= BOOT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A redirect during an unacknowledged request cannot
    // move the address, so it parks in DRAIN until the old request completes.
    always_comb begin
        next_state = state;
        case (state)
            BOOT:  next_state = REQ;
            REQ: begin
                if (IMemAck && !Redirect) begin
                    next_state = HOLD;
                end else if (!IMemAck && Redirect) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (IMemAck) begin
                    next_state = REQ;
                end
            end
            HOLD: begin
                if (Redirect || InstrReady) begin
                    next_state = REQ;
                end
            end
            default: next_state = BOOT;
        endcase
    end

    // Memory request outputs decoded from state; the address is simply the
    // fetch PC, which never changes while a request is outstanding.
    always_comb begin
        IMemReq  = (state == REQ) || (state == DRAIN);
        IMemAddr = fetch_pc;
    end

    // Datapath: fetch PC, pending redirect target and the registered
    // instruction presented to decode.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            fetch_pc       <= RESET_PC;
            pending_target <= 32'h0;
            pc_q           <= RESET_PC;
            instr_q        <= NOP_INSTR;
            instr_valid_q  <= 1'b0;
            misalign_q     <= 1'b0;
        end else begin
            misalign_q <= redirect_taken && (RedirectTarget[1:0] != 2'b00);
            case (state)
                REQ: begin
                    if (IMemAck) begin
                        if (Redirect) begin
                            fetch_pc <= aligned_target;
                        end else begin
                            instr_q       <= IMemRData;
                            pc_q          <= fetch_pc;
                            instr_valid_q <= 1'b1;
                        end
                    end else if (Redirect) begin
                        pending_target <= aligned_target;
                    end
                end
                DRAIN: begin
                    if (Redirect) begin
                        pending_target <= aligned_target;
                    end
                    if (IMemAck) begin
                        fetch_pc <= Redirect ? aligned_target : pending_target;
                    end
                end
                HOLD: begin
                    if (Redirect) begin
                        instr_valid_q <= 1'b0;
                        instr_q       <= NOP_INSTR;
                        fetch_pc      <= aligned_target;
                    end else if (InstrReady) begin
                        instr_valid_q <= 1'b0;
                        instr_q       <= NOP_INSTR;
                        fetch_pc      <= fetch_pc + 32'd4;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Instr      = instr_q;
    assign PC         = pc_q;
    assign PCPlus4    = pc_q + 32'd4;
    assign InstrValid = instr_valid_q;
    assign Misalign   = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Drives the fetch unit with directed sequences and then randomized memory
// acks, decode ready, and redirects. A transaction-level model tracks what
// request should be outstanding and which instruction should be held, and
// every cycle the DUT outputs are compared against it. A second instance
// with a wrap-around reset PC covers the address wrap and mid-request reset.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        misalign;

    logic        w_rst_n;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;
    logic        w_valid;
    logic        w_ready;
    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_misalign;

    int errors = 0;
    int checks = 0;

    // Transaction-level model: is the unit booting, is a request outstanding
    // (and is its answer already stale), or is an instruction waiting.
    bit          m_boot;
    bit          m_busy;
    bit          m_stale;
    bit          m_held;
    logic [31:0] m_req_addr;
    logic [31:0] m_pending;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    bit          m_mis;

    instr_fetch_unit dut (
        .CLK(clk), .RSTn(rst_n),
        .IMemReq(imem_req), .IMemAddr(imem_addr),
        .IMemAck(imem_ack), .IMemRData(imem_rdata),
        .Instr(instr), .PC(pc), .PCPlus4(pc_plus4),
        .InstrValid(instr_valid), .InstrReady(instr_ready),
        .Redirect(redirect), .RedirectTarget(redirect_target),
        .Misalign(misalign)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .CLK(clk), .RSTn(w_rst_n),
        .IMemReq(w_req), .IMemAddr(w_addr),
        .IMemAck(w_ack), .IMemRData(w_rdata),
        .Instr(w_instr), .PC(w_pc), .PCPlus4(w_pc_plus4),
        .InstrValid(w_valid), .InstrReady(w_ready),
        .Redirect(w_redirect), .RedirectTarget(w_target),
        .Misalign(w_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_boot     = 1'b1;
        m_busy     = 1'b0;
        m_stale    = 1'b0;
        m_held     = 1'b0;
        m_req_addr = 32'h0;
        m_pending  = 32'h0;
        m_instr    = NOP;
        m_pc       = 32'h0;
        m_mis      = 1'b0;
    endtask

    // One cycle: drive inputs at the falling edge, compare outputs with the
    // model, advance the model with the driven inputs, return 1 after the
    // rising edge so directed checks can look at the new values.
    task automatic applyStimulus(input bit ack, input logic [31:0] rdata, input bit ready,
                                 input bit redir, input logic [31:0] tgt);
        logic [31:0] al;
        @(negedge clk);
        imem_ack        = ack;
        imem_rdata      = rdata;
        instr_ready     = ready;
        redirect        = redir;
        redirect_target = tgt;

        checkOutput("imem_req", {31'b0, imem_req}, {31'b0, m_busy});
        if (m_busy) checkOutput("imem_addr", imem_addr, m_req_addr);
        checkOutput("instr_valid", {31'b0, instr_valid}, {31'b0, m_held});
        checkOutput("instr", instr, m_instr);
        checkOutput("pc", pc, m_pc);
        checkOutput("pc_plus4", pc_plus4, m_pc + 32'd4);
        checkOutput("misalign", {31'b0, misalign}, {31'b0, m_mis});

        al    = {tgt[31:2], 2'b00};
        m_mis = !m_boot && redir && (tgt[1:0] != 2'b00);
        if (m_boot) begin
            m_boot = 1'b0;
            m_busy = 1'b1;
        end else if (m_busy && !m_stale) begin
            if (ack && !redir) begin
                m_busy  = 1'b0;
                m_held  = 1'b1;
                m_instr = rdata;
                m_pc    = m_req_addr;
            end else if (ack && redir) begin
                m_req_addr = al;
            end else if (redir) begin
                m_stale   = 1'b1;
                m_pending = al;
            end
        end else if (m_busy && m_stale) begin
            if (redir) m_pending = al;
            if (ack) begin
                m_req_addr = m_pending;
                m_stale    = 1'b0;
            end
        end else if (m_held) begin
            if (redir || ready) begin
                m_held     = 1'b0;
                m_busy     = 1'b1;
                m_instr    = NOP;
                m_req_addr = redir ? al : m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        w_rst_n = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_target = 32'h0;
        w_ack = 1'b0; w_rdata = 32'h0; w_ready = 1'b0;
        w_redirect = 1'b0; w_target = 32'h0;
        modelReset();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_req", {31'b0, imem_req}, 32'h0);
        checkOutput("reset_valid", {31'b0, instr_valid}, 32'h0);
        checkOutput("reset_instr", instr, 32'h0000_0013);
        checkOutput("reset_pc", pc, 32'h0);
        checkOutput("reset_mis", {31'b0, misalign}, 32'h0);
        rst_n = 1'b1;

        // Back-to-back fetch with immediate acks and decode always ready.
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        checkOutput("t1_addr0", imem_addr, 32'h0);
        checkOutput("t1_req0", {31'b0, imem_req}, 32'h1);
        applyStimulus(1, 32'h0050_0093, 1, 0, 32'h0);
        checkOutput("t1_instr0", instr, 32'h0050_0093);
        checkOutput("t1_pc0", pc, 32'h0);
        checkOutput("t1_valid0", {31'b0, instr_valid}, 32'h1);
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        checkOutput("t1_addr1", imem_addr, 32'h4);
        checkOutput("t1_valid_gap", {31'b0, instr_valid}, 32'h0);
        applyStimulus(1, 32'h00A0_0113, 1, 0, 32'h0);
        checkOutput("t1_instr1", instr, 32'h00A0_0113);
        checkOutput("t1_pc1", pc, 32'h4);

        // Decode stalls for five cycles, then consumes.
        repeat (5) applyStimulus(1, 32'hDEAD_BEEF, 0, 0, 32'h0);
        checkOutput("t2_instr", instr, 32'h00A0_0113);
        checkOutput("t2_req", {31'b0, imem_req}, 32'h0);
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        checkOutput("t2_next_addr", imem_addr, 32'h8);

        // Two redirects during a slow request: address holds, last one wins.
        applyStimulus(0, 32'h0, 0, 1, 32'h100);
        checkOutput("t3_addr_hold0", imem_addr, 32'h8);
        applyStimulus(0, 32'h0, 0, 1, 32'h200);
        checkOutput("t3_addr_hold1", imem_addr, 32'h8);
        applyStimulus(1, 32'h1234_5678, 1, 0, 32'h0);
        checkOutput("t3_discard", {31'b0, instr_valid}, 32'h0);
        checkOutput("t3_new_addr", imem_addr, 32'h200);

        // Redirect beats InstrReady while holding an instruction at 0x40.
        applyStimulus(1, 32'h0, 0, 1, 32'h40);
        applyStimulus(1, 32'h0000_0293, 0, 0, 32'h0);
        checkOutput("t4_pc", pc, 32'h40);
        applyStimulus(0, 32'h0, 1, 1, 32'h80);
        checkOutput("t4_valid", {31'b0, instr_valid}, 32'h0);
        checkOutput("t4_instr", instr, 32'h0000_0013);
        checkOutput("t4_addr", imem_addr, 32'h80);

        // Misaligned redirect target.
        applyStimulus(0, 32'h0, 0, 1, 32'h103);
        checkOutput("t5_mis_on", {31'b0, misalign}, 32'h1);
        applyStimulus(1, 32'h0, 0, 0, 32'h0);
        checkOutput("t5_mis_off", {31'b0, misalign}, 32'h0);
        checkOutput("t5_addr", imem_addr, 32'h100);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(1, 0) == 1, $urandom,
                          $urandom_range(2, 0) != 0,
                          $urandom_range(7, 0) == 0, $urandom);
        end

        // Wrap-around reset PC and reset asserted in the middle of a request.
        @(posedge clk);
        #1;
        w_rst_n = 1'b1;
        @(negedge clk);
        checkOutput("w_boot_req", {31'b0, w_req}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("w_addr0", w_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        w_ack = 1'b1;
        w_rdata = 32'h0050_0093;
        @(posedge clk);
        #1;
        w_ack = 1'b0;
        checkOutput("w_pc", w_pc, 32'hFFFF_FFFC);
        checkOutput("w_pc_plus4", w_pc_plus4, 32'h0);
        @(negedge clk);
        w_ready = 1'b1;
        @(posedge clk);
        #1;
        w_ready = 1'b0;
        checkOutput("w_wrap_addr", w_addr, 32'h0);
        checkOutput("w_wrap_req", {31'b0, w_req}, 32'h1);
        #1;
        w_rst_n = 1'b0;
        #1;
        checkOutput("w_rst_req", {31'b0, w_req}, 32'h0);
        checkOutput("w_rst_pc", w_pc, 32'hFFFF_FFFC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
